// File: rtl/cordic_result_collector.sv
// cordic_result_collector: picks the meaningful CORDIC outputs per operation, removes vectoring gain,
// buffers results in a show-ahead FIFO and hands out request credits so the non-stallable pipeline never overflows it
module cordic_result_collector #(
    parameter int INTEGER_BITS    = 3,
    parameter int FRACTIONAL_BITS = 30,
    parameter int FIFO_DEPTH      = 8,
    localparam int BITS           = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_issue,
    output logic                   o_issue_ok,
    input  logic                   i_valid,
    input  logic signed [BITS-1:0] i_x,
    input  logic signed [BITS-1:0] i_y,
    input  logic signed [BITS-1:0] i_z,
    input  logic [1:0]             i_mode,
    input  logic                   i_rot_en,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [BITS-1:0] o_res0,
    output logic signed [BITS-1:0] o_res1,
    output logic                   o_res1_en,
    output logic [1:0]             o_mode,
    output logic                   o_rot_en,
    output logic                   o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = 2 * BITS + 4;
    localparam int PW = 2 * BITS + 1;
    localparam longint KC = longint'(0.6072529350 * (2.0 ** FRACTIONAL_BITS));
    localparam longint KH = longint'(1.2074970678 * (2.0 ** FRACTIONAL_BITS));
    localparam logic signed [BITS-1:0] INV_K_CIRC = BITS'(KC);
    localparam logic signed [BITS-1:0] INV_K_HYP  = BITS'(KH);
    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRACTIONAL_BITS - 1);
    localparam logic signed [PW-1:0] SMAX = PW'({1'b0, {(BITS-1){1'b1}}});
    localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    logic lin, hyp;
    logic signed [BITS-1:0] k, sel0, sel1, mul_sat;
    logic signed [2*BITS-1:0] prod;
    logic signed [PW-1:0] scaled;

    // modes 00 and 10 (-2) both behave as linear
    assign lin     = ~i_mode[0];
    assign hyp     = i_mode == 2'b11;
    assign k       = hyp ? INV_K_HYP : INV_K_CIRC;
    assign prod    = (2*BITS)'(i_x) * (2*BITS)'(k);
    assign scaled  = (PW'(prod) + HALF) >>> FRACTIONAL_BITS;
    assign mul_sat = scaled > SMAX ? SMAX[BITS-1:0] : scaled < SMIN ? SMIN[BITS-1:0] : scaled[BITS-1:0];
    assign sel0    = lin ? (i_rot_en ? i_y : i_z) : (i_rot_en ? i_x : i_z);
    assign sel1    = lin ? '0 : (i_rot_en ? i_y : mul_sat);

    logic post_valid;
    logic [W-1:0] post_data, head;

    always_ff @(posedge i_clk) begin
        post_valid <= i_rst_n & i_valid;
        post_data  <= {sel0, sel1, ~lin, i_mode, i_rot_en};
    end

    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, reserved;
    logic empty, full, pop, wr, take, dec;

    assign empty      = count == '0;
    assign full       = count == DEPTH;
    assign pop        = o_valid & i_ready;
    assign wr         = post_valid & (~full | pop);
    // an issue coinciding with a pop reuses the slot being freed
    assign take       = i_issue & (o_issue_ok | pop);
    assign dec        = pop & (reserved != '0);
    assign o_issue_ok = reserved < DEPTH;
    assign o_valid    = ~empty;
    assign head       = empty ? '0 : mem[rd_ptr];
    assign {o_res0, o_res1, o_res1_en, o_mode, o_rot_en} = head;

    always_ff @(posedge i_clk) begin
        if (wr)
            mem[wr_ptr] <= post_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            reserved   <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count      <= count + (AW+1)'(wr) - (AW+1)'(pop);
            reserved   <= reserved + (AW+1)'(take) - (AW+1)'(dec);
            o_overflow <= o_overflow | (post_valid & ~wr) | (i_issue & ~take);
        end
    end
endmodule

// File: tb/tb_cordic_result_collector.sv
// tb_cordic_result_collector: scenario tasks plus a randomized scoreboard run against an arithmetic reference model
module tb_cordic_result_collector;
    localparam int B = 33;

    typedef struct packed {
        logic [B-1:0] r0;
        logic [B-1:0] r1;
        logic         en;
        logic [1:0]   mode;
        logic         rot;
    } res_t;

    typedef struct {
        res_t r;
        int   vis;
    } pend_t;

    logic clk = 0, rst_n = 0, issue = 0, valid = 0, ready = 0, rot_en = 0;
    logic [1:0] mode = 0;
    logic [B-1:0] ix = 0, iy = 0, iz = 0;
    logic issue_ok, o_valid, o_res1_en, o_rot_en, o_overflow;
    logic [B-1:0] o_res0, o_res1;
    logic [1:0] o_mode;
    res_t got;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign got = {o_res0, o_res1, o_res1_en, o_mode, o_rot_en};

    cordic_result_collector dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue(issue), .o_issue_ok(issue_ok),
        .i_valid(valid), .i_x(ix), .i_y(iy), .i_z(iz), .i_mode(mode), .i_rot_en(rot_en),
        .o_valid(o_valid), .i_ready(ready), .o_res0(o_res0), .o_res1(o_res1),
        .o_res1_en(o_res1_en), .o_mode(o_mode), .o_rot_en(o_rot_en), .o_overflow(o_overflow)
    );

    function automatic logic [B-1:0] gain(logic signed [B-1:0] x, longint kk);
        longint p;
        p = (longint'(x) * kk + (64'sd1 <<< 29)) >>> 30;
        if (p > 64'sd4294967295) p = 64'sd4294967295;
        if (p < -64'sd4294967296) p = -64'sd4294967296;
        return B'(p);
    endfunction

    function automatic res_t model(logic [1:0] m, logic rot, logic [B-1:0] x, logic [B-1:0] y, logic [B-1:0] z);
        res_t r;
        int mv;
        mv = $signed(m);
        r.mode = m;
        r.rot  = rot;
        if (mv == 1 || mv == -1) begin
            r.en = 1;
            r.r0 = rot ? x : z;
            r.r1 = rot ? y : gain(x, mv == 1 ? 64'sd652032874 : 64'sd1296540104);
        end else begin
            r.en = 0;
            r.r0 = rot ? y : z;
            r.r1 = '0;
        end
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [1:0] m, logic rot, logic [B-1:0] x, logic [B-1:0] y, logic [B-1:0] z);
        valid = v; mode = m; rot_en = rot; ix = x; iy = y; iz = z;
    endtask

    task automatic put_rand(output res_t e);
        logic [1:0] m;
        logic r;
        logic [B-1:0] x, y, z;
        m = 2'($urandom);
        r = 1'($urandom);
        x = {1'($urandom), 32'($urandom)};
        y = {1'($urandom), 32'($urandom)};
        z = {1'($urandom), 32'($urandom)};
        drive(1, m, r, x, y, z);
        e = model(m, r, x, y, z);
    endtask

    task automatic test_reset;
        rst_n = 0; issue = 0; ready = 0;
        drive(0, 0, 0, 0, 0, 0);
        step; step;
        rst_n = 1;
        step;
        checks++;
        if ({o_valid, issue_ok, o_overflow} !== 3'b010) begin
            errors++; $display("FAIL reset_flags: got valid/ok/ovf=%b want 010", {o_valid, issue_ok, o_overflow});
        end
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", got);
        end
    endtask

    task automatic test_gain;
        res_t e;
        ready = 0;
        drive(1, 2'b01, 0, 33'd1768195364, 0, 33'd843314857);
        e = model(2'b01, 0, 33'd1768195364, 0, 33'd843314857);
        step;
        valid = 0;
        step;
        checks++;
        if (o_valid !== 1 || got !== e) begin
            errors++; $display("FAIL gain_model: got v=%b %h want v=1 %h", o_valid, got, e);
        end
        checks++;
        if (o_res0 !== 33'd843314857 || o_res1 < 33'd1073741823 || o_res1 > 33'd1073741825 || o_res1_en !== 1) begin
            errors++; $display("FAIL gain_values: got res0=%0d res1=%0d en=%b want 843314857 1073741824+-1 1", o_res0, o_res1, o_res1_en);
        end
        step;
        checks++;
        if (o_valid !== 1 || got !== e) begin
            errors++; $display("FAIL gain_hold: got %h want %h", got, e);
        end
        ready = 1;
        step;
        ready = 0;
        checks++;
        if (o_valid !== 0 || got !== '0) begin
            errors++; $display("FAIL gain_pop: got v=%b %h want v=0 0", o_valid, got);
        end
    endtask

    task automatic test_mode_map;
        logic [1:0] ms [7] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10};
        logic rs [7] = '{1, 0, 1, 0, 1, 0, 1};
        res_t e [7];
        ready = 1;
        for (int k = 0; k < 10; k++) begin
            if (k < 7) begin
                drive(1, ms[k], rs[k], 33'h10000000, 33'h20000000, 33'h30000000);
                e[k] = model(ms[k], rs[k], 33'h10000000, 33'h20000000, 33'h30000000);
            end else begin
                valid = 0;
            end
            step;
            checks++;
            if (o_valid !== (k >= 1 && k <= 7)) begin
                errors++; $display("FAIL map_valid[%0d]: got %b want %b", k, o_valid, (k >= 1 && k <= 7));
            end
            if (k >= 1 && k <= 7) begin
                checks++;
                if (got !== e[k-1]) begin
                    errors++; $display("FAIL map_data[%0d]: got %h want %h", k - 1, got, e[k-1]);
                end
            end
        end
        ready = 0;
    endtask

    task automatic test_saturation;
        logic [B-1:0] xs [2] = '{33'h0FFFFFFFF, 33'h100000000};
        logic [B-1:0] want [2] = '{33'h0FFFFFFFF, 33'h100000000};
        for (int i = 0; i < 2; i++) begin
            ready = 0;
            drive(1, 2'b11, 0, xs[i], 0, 33'd5);
            step;
            valid = 0;
            step;
            checks++;
            if (o_valid !== 1 || o_res1 !== want[i] || got !== model(2'b11, 0, xs[i], 0, 33'd5)) begin
                errors++; $display("FAIL saturate[%0d]: got v=%b res1=%h want v=1 res1=%h", i, o_valid, o_res1, want[i]);
            end
            ready = 1;
            step;
        end
        ready = 0;
    endtask

    task automatic test_credits;
        res_t e [8];
        test_reset;
        for (int i = 0; i < 8; i++) begin
            issue = 1;
            step;
            checks++;
            if (issue_ok !== (i < 7)) begin
                errors++; $display("FAIL credit_fill[%0d]: got ok=%b want %b", i, issue_ok, (i < 7));
            end
        end
        issue = 0;
        for (int i = 0; i < 8; i++) begin
            put_rand(e[i]);
            step;
        end
        valid = 0;
        step; step;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid !== 1 || got !== e[0] || issue_ok !== 0) begin
                errors++; $display("FAIL credit_hold[%0d]: got v=%b ok=%b %h want v=1 ok=0 %h", i, o_valid, issue_ok, got, e[0]);
            end
            step;
        end
        ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_valid !== 1 || got !== e[i]) begin
                errors++; $display("FAIL credit_pop[%0d]: got v=%b %h want v=1 %h", i, o_valid, got, e[i]);
            end
            step;
            if (i == 0) begin
                checks++;
                if (issue_ok !== 1) begin
                    errors++; $display("FAIL credit_return: got ok=%b want 1", issue_ok);
                end
            end
        end
        ready = 0;
        checks++;
        if (o_valid !== 0 || issue_ok !== 1 || o_overflow !== 0) begin
            errors++; $display("FAIL credit_drained: got v=%b ok=%b ovf=%b want 0 1 0", o_valid, issue_ok, o_overflow);
        end
    endtask

    task automatic test_credit_collide;
        res_t e [8];
        test_reset;
        issue = 1;
        for (int i = 0; i < 8; i++) step;
        issue = 0;
        for (int i = 0; i < 8; i++) begin
            put_rand(e[i]);
            step;
        end
        valid = 0;
        step; step;
        ready = 1; issue = 1;
        step;
        ready = 0; issue = 0;
        checks++;
        if (issue_ok !== 0 || got !== e[1]) begin
            errors++; $display("FAIL collide_ok: got ok=%b %h want ok=0 %h", issue_ok, got, e[1]);
        end
        step;
        checks++;
        if (issue_ok !== 0) begin
            errors++; $display("FAIL collide_hold: got ok=%b want 0", issue_ok);
        end
        ready = 1;
        step;
        ready = 0;
        checks++;
        if (issue_ok !== 1 || got !== e[2]) begin
            errors++; $display("FAIL collide_release: got ok=%b %h want ok=1 %h", issue_ok, got, e[2]);
        end
    endtask

    task automatic test_overflow;
        res_t e [8];
        res_t extra;
        test_reset;
        for (int i = 0; i < 8; i++) begin
            put_rand(e[i]);
            step;
        end
        valid = 0;
        step; step;
        checks++;
        if (o_overflow !== 0) begin
            errors++; $display("FAIL ovf_full: got %b want 0", o_overflow);
        end
        put_rand(extra);
        step;
        valid = 0;
        checks++;
        if (o_overflow !== 0) begin
            errors++; $display("FAIL ovf_early: got %b want 0", o_overflow);
        end
        step;
        checks++;
        if (o_overflow !== 1) begin
            errors++; $display("FAIL ovf_set: got %b want 1", o_overflow);
        end
        step; step;
        ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_valid !== 1 || got !== e[i] || o_overflow !== 1) begin
                errors++; $display("FAIL ovf_contents[%0d]: got v=%b ovf=%b %h want v=1 ovf=1 %h", i, o_valid, o_overflow, got, e[i]);
            end
            step;
        end
        ready = 0;
        checks++;
        if (o_valid !== 0 || o_overflow !== 1) begin
            errors++; $display("FAIL ovf_dropped: got v=%b ovf=%b want 0 1", o_valid, o_overflow);
        end
        test_reset;
        for (int i = 0; i < 9; i++) begin
            issue = 1;
            step;
            if (i == 7) begin
                checks++;
                if (o_overflow !== 0) begin
                    errors++; $display("FAIL ovf_credit_early: got %b want 0", o_overflow);
                end
            end
        end
        issue = 0;
        checks++;
        if (o_overflow !== 1 || issue_ok !== 0) begin
            errors++; $display("FAIL ovf_credit: got ovf=%b ok=%b want 1 0", o_overflow, issue_ok);
        end
    endtask

    task automatic test_random;
        pend_t q[$];
        res_t e;
        int cyc;
        cyc = 0;
        test_reset;
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (o_valid !== (q.size() > 0 && q[0].vis <= cyc)) begin
                errors++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, o_valid, (q.size() > 0 && q[0].vis <= cyc));
            end
            if (o_valid && q.size() > 0) begin
                checks++;
                if (got !== q[0].r) begin
                    errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, got, q[0].r);
                end
            end
            ready = $urandom_range(0, 3) != 0;
            if (ready && q.size() > 0 && q[0].vis <= cyc) void'(q.pop_front());
            if (q.size() < 8 && $urandom_range(0, 2) != 0) begin
                put_rand(e);
                q.push_back('{e, cyc + 2});
            end else begin
                valid = 0;
            end
            step;
            cyc++;
        end
        valid = 0;
        ready = 1;
        for (int i = 0; i < 12; i++) step;
        ready = 0;
        checks++;
        if (o_valid !== 0 || o_overflow !== 0) begin
            errors++; $display("FAIL rand_end: got v=%b ovf=%b want 0 0", o_valid, o_overflow);
        end
    endtask

    initial begin
        test_reset;
        test_gain;
        test_mode_map;
        test_saturation;
        test_credits;
        test_credit_collide;
        test_overflow;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/cordic_result_collector.md
# cordic_result_collector

Back-end companion to the pipelined CORDIC core: consumes its result stream (`valid` plus `x`/`y`/`z`/`mode`/`rot_en`), selects the meaningful result(s) for each operation, and removes the CORDIC gain from vectoring-mode magnitudes. Results are buffered in a FIFO and presented on a valid/ready stream. The CORDIC pipeline cannot stall, so the block also issues credits to the request side. A request may enter the CORDIC only when a FIFO slot is guaranteed for its result.

## Interface
- `INTEGER_BITS`, 3: integer bits including sign (Q3.30 by default).
- `FRACTIONAL_BITS`, 30: fraction bits; `BITS = INTEGER_BITS + FRACTIONAL_BITS`.
- `FIFO_DEPTH`, 8: result FIFO entries; must be a power of 2, ≥ 2.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: synchronous reset, active-low.
- `i_issue` in 1: request pushed into the CORDIC this cycle; legal only while `o_issue_ok` = 1.
- `o_issue_ok` out 1: credit available.
- `i_valid` in 1: CORDIC result valid.
- `i_x`, `i_y`, `i_z` in BITS each: signed CORDIC outputs.
- `i_mode` in 2: signed; −1 = hyperbolic, 0 = linear, 1 = circular.
- `i_rot_en` in 1: 1 = rotation, 0 = vectoring.
- `o_valid` out 1: result available.
- `i_ready` in 1: downstream accepts.
- `o_res0`, `o_res1` out BITS each: signed results.
- `o_res1_en` out 1: `o_res1` is meaningful.
- `o_mode` out 2: mode echoed with the result.
- `o_rot_en` out 1: `rot_en` echoed with the result.
- `o_overflow` out 1: sticky error flag.

## Operation
Result selection, applied in the post stage:

| mode | rot_en | res0 | res1 | res1_en |
|---|---|---|---|---|
| linear | 1 | y | 0 | 0 |
| linear | 0 | z | 0 | 0 |
| hyperbolic | 1 | x (cosh) | y (sinh) | 1 |
| hyperbolic | 0 | z (atanh) | x·INV_K_HYP | 1 |
| circular | 1 | x (cos) | y (sin) | 1 |
| circular | 0 | z (atan) | x·INV_K_CIRC | 1 |

- `mode` = −2 (encoding 2'b10) is treated as linear.

Gain constants:
- INV_K_CIRC = round(0.6072529350 · 2^FRACTIONAL_BITS). This is ≈ 652032874 at the default width.
- INV_K_HYP = round(1.2074970678 · 2^FRACTIONAL_BITS). This is ≈ 1296540104 at the default width.
- Both are computed at elaboration from the parameters.

Multiply arithmetic:
- Full signed product of width 2·BITS.
- Add 2^(FRACTIONAL_BITS−1), then arithmetic shift right by FRACTIONAL_BITS (round half toward +∞).
- Saturate to [−2^(BITS−1), 2^(BITS−1)−1].

Post stage:
- One register stage after selection and multiply.
- Output: valid bit plus {res0, res1, res1_en, mode, rot_en}.

FIFO:
- Show-ahead; head entry drives the outputs.
- Write when the post-stage valid bit is set.
- Pop when `o_valid && i_ready`.
- Simultaneous write and pop while full is legal: occupancy unchanged.

Credit counter `reserved`, range 0..FIFO_DEPTH:
- +1 on `i_issue`; −1 on pop; both in the same cycle leaves it unchanged.
- `o_issue_ok` = (`reserved` < FIFO_DEPTH), a combinational function of the registered counter.
- `i_issue` while `o_issue_ok` = 0: ignored, and sets `o_overflow`.

Overflow handling:
- A post-stage write while the FIFO is full and no pop occurs: the result is dropped and `o_overflow` is set.
- `o_overflow` is cleared only by reset.

## Timing
Reset (`i_rst_n` = 0 at a rising edge):
- Clears `reserved`, FIFO pointers and occupancy, the post-stage valid bit, and `o_overflow`.
- Reset values: `o_valid` = 0, `o_issue_ok` = 1 (FIFO_DEPTH ≥ 1), `o_overflow` = 0.
- `o_res0`, `o_res1`, `o_mode` = 0 and `o_rot_en`, `o_res1_en` = 0 while the FIFO is empty; the data outputs are forced to 0 whenever empty.
- Reset mid-operation discards all buffered and in-flight results. The request side must also flush the CORDIC, because stale results arriving later would be written and counted as overflow only if the FIFO is full.

Latency:
- `i_valid` sampled at edge E_t → post register at E_t.
- FIFO write at E_{t+1} → `o_valid` = 1 during cycle t+2 if the FIFO was empty.
- Back-to-back results: one per cycle, in order, no bubbles.
- With the FIFO empty, a result written at E_{t+1} is not poppable before cycle t+2 (no bypass).

Handshake:
- While `o_valid` = 1 and `i_ready` = 0, all outputs hold stable.
- On pop, the next entry appears in the following cycle.

Credit timing:
- Counter updates are visible in `o_issue_ok` the cycle after the edge at which they are sampled.

## Test plan
- **Reset:** hold `i_rst_n` = 0 for 2 cycles, release → `o_valid` = 0, `o_issue_ok` = 1, `o_overflow` = 0, data outputs 0.
- **Circular vectoring gain:**
  - Stimulus: `i_valid` with mode = 1, rot_en = 0, `i_x` = 1768195364 (1.64676 in Q3.30), `i_z` = 843314857.
  - Response: 2 cycles later `o_res0` = 843314857, `o_res1` = 1073741824 ±1, `o_res1_en` = 1.
- **Mode mapping:** six consecutive results, one per mode/rot_en combination, with x = 0x10000000, y = 0x20000000, z = 0x30000000, `i_ready` = 1.
  - Outputs appear in order on consecutive cycles with `res0`/`res1` per the selection table.
  - Linear entries have `res1` = 0 and `res1_en` = 0.
- **Saturation:** hyperbolic vectoring with `i_x` = 0x0FFFFFFFF (max positive) → `o_res1` = 2^32−1.
- **Credits/backpressure:**
  - Stimulus: `i_ready` = 0; pulse `i_issue` 8 times, then feed 8 results.
  - `o_issue_ok` falls the cycle after the 8th issue; the FIFO holds 8; `o_valid` stays 1 and `o_res0` stays stable.
  - Then raise `i_ready`: 8 pops on 8 consecutive cycles in order; `o_issue_ok` returns to 1 one cycle after the first pop.
  - Simultaneous `i_issue` and pop at `reserved` = 8 keeps `o_issue_ok` = 0 and the count unchanged.
- **Overflow:**
  - Stimulus: with the FIFO full and `i_ready` = 0, inject a 9th `i_valid`.
  - Response: `o_overflow` = 1 two cycles later; the FIFO contents are unchanged.
  - `o_overflow` stays 1 until `i_rst_n` = 0.
